// File: rtl/video_seq_pkg.sv
// Shared state encoding, 1280x720 timing constants and a counter-width helper
// for the video frame sequencer.
package video_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KICK,
        WAIT_DONE,
        CHECK,
        GAP,
        DONE
    } state_t;

    localparam int H_TOTAL = 1650;
    localparam int V_TOTAL = 750;
    localparam int H_DISP  = 1280;
    localparam int V_DISP  = 720;

    // Bits needed to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/video_geom_counter.sv
// Per-frame geometry counter: valid cycles (pixels) and valid rising edges (lines).
// Both counts saturate instead of wrapping.
module video_geom_counter #(
    parameter int PIX_W  = 21,
    parameter int LINE_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic              valid,
    output logic [PIX_W-1:0]  pixels,
    output logic [LINE_W-1:0] lines
);

    logic valid_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pixels  <= '0;
            lines   <= '0;
            valid_q <= 1'b0;
        end else if (en) begin
            valid_q <= valid;
            if (valid && pixels != '1)
                pixels <= pixels + 1'b1;
            if (valid && !valid_q && lines != '1)
                lines <= lines + 1'b1;
        end
    end

endmodule

// File: rtl/video_frame_sequencer.sv
// Frame sequencer: kicks the video source FRAME_NUM times with GAP_CYCLES between
// frames, with a done timeout. Define SEQ_GEOM_CHECK_EN to add per-frame geometry checking.
module video_frame_sequencer
    import video_seq_pkg::*;
#(
    parameter int FRAME_NUM  = 4,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 1500000,
    parameter int EXP_PIXELS = 921600,
    parameter int EXP_LINES  = 720
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        src_begin,
    input  logic        src_done,
    input  logic        src_vsync,
    input  logic        src_hsync,
    input  logic        src_valid,
    output logic        busy,
    output logic [15:0] frame_idx,
    output logic        seq_done,
    output logic        err_timeout,
    output logic        err_geom
);

    localparam int FW = cnt_w(FRAME_NUM + 1);
    localparam int TW = cnt_w(TIMEOUT);
    localparam int GW = cnt_w(GAP_CYCLES);

    state_t        state;
    logic [FW-1:0] frame_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [GW-1:0] gap_cnt;

    assign frame_idx = 16'(frame_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            src_begin   <= 1'b0;
            busy        <= 1'b0;
            seq_done    <= 1'b0;
            err_timeout <= 1'b0;
            frame_cnt   <= '0;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
        end else if (abort) begin
            state     <= IDLE;
            src_begin <= 1'b0;
            busy      <= 1'b0;
            seq_done  <= 1'b0;
        end else begin
            // Pulses default low; transitions below raise them for the entered state.
            src_begin <= 1'b0;
            seq_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        frame_cnt   <= '0;
                        err_timeout <= 1'b0;
                        busy        <= 1'b1;
                        src_begin   <= 1'b1;
                        state       <= KICK;
                    end
                end
                KICK: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (src_done) begin
                        state <= CHECK;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    frame_cnt <= frame_cnt + 1'b1;
                    gap_cnt   <= '0;
                    if (frame_cnt == FW'(FRAME_NUM - 1)) begin
                        seq_done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        src_begin <= 1'b1;
                        state     <= KICK;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_GEOM_CHECK_EN
    // One extra bit keeps a saturated count distinct from the expected value.
    localparam int PW = $clog2(EXP_PIXELS + 1) + 1;
    localparam int LW = $clog2(EXP_LINES + 1) + 1;

    logic [PW-1:0] pixels;
    logic [LW-1:0] lines;
    logic          geom_bad;
    logic          unused_sync;

    assign unused_sync = src_vsync ^ src_hsync;

    video_geom_counter #(
        .PIX_W  (PW),
        .LINE_W (LW)
    ) u_geom (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == KICK),
        .en     (state == WAIT_DONE),
        .valid  (src_valid),
        .pixels (pixels),
        .lines  (lines)
    );

    assign geom_bad = (pixels != PW'(EXP_PIXELS)) || (lines != LW'(EXP_LINES));

    always_ff @(posedge clk) begin
        if (rst)
            err_geom <= 1'b0;
        else if (abort)
            err_geom <= err_geom;
        else if (state == IDLE && start)
            err_geom <= 1'b0;
        else if (state == CHECK && geom_bad)
            err_geom <= 1'b1;
    end
`else
    logic unused_stream;

    assign unused_stream = src_vsync ^ src_hsync ^ src_valid;
    assign err_geom      = 1'b0;
`endif

endmodule

// File: tb/tb_video_frame_sequencer.sv
// Bench for video_frame_sequencer: event-timestamp reference model checked every
// cycle, plus directed sequences with hand-computed expectations.
module tb_video_frame_sequencer;

    localparam int FN   = 2;
    localparam int GAP  = 16;
    localparam int TMO  = 100;
    localparam int PPL  = 8;
    localparam int NL   = 4;
    localparam int EXPP = PPL * NL;
    localparam int EXPL = NL;
`ifdef SEQ_GEOM_CHECK_EN
    localparam bit GEOM_ON = 1'b1;
`else
    localparam bit GEOM_ON = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic src_done = 1'b0, src_vsync = 1'b0, src_hsync = 1'b0, src_valid = 1'b0;
    logic src_begin, busy, seq_done, err_timeout, err_geom;
    logic [15:0] frame_idx;

    always #5 clk = ~clk;

    video_frame_sequencer #(
        .FRAME_NUM  (FN),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TMO),
        .EXP_PIXELS (EXPP),
        .EXP_LINES  (EXPL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .src_begin   (src_begin),
        .src_done    (src_done),
        .src_vsync   (src_vsync),
        .src_hsync   (src_hsync),
        .src_valid   (src_valid),
        .busy        (busy),
        .frame_idx   (frame_idx),
        .seq_done    (seq_done),
        .err_timeout (err_timeout),
        .err_geom    (err_geom)
    );

    int passed = 0, total = 0;
    int cyc = 0;
    int gen_pix = 0, gen_lines = 0, done_cyc = 0;
    int n_beg = 0, n_sd = 0;
    bit cmp_en = 1'b0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (src_begin === 1'b1) n_beg++;
        if (seq_done === 1'b1) n_sd++;
    end

    // Reference model: tracks the edges at which each event is due rather than a state.
    bit x_busy = 0, x_begin = 0, x_sdone = 0, x_et = 0, x_eg = 0;
    int x_idx = 0;
    int e = 0, kick_at = -10, check_at = -10, fin_at = -10, w0 = 0;
    bit waiting = 0;

    always @(posedge clk) begin
        e++;
        x_begin = 0;
        x_sdone = 0;
        if (rst) begin
            x_busy = 0; x_idx = 0; x_et = 0; x_eg = 0;
            kick_at = -10; check_at = -10; fin_at = -10; waiting = 0;
        end else if (abort) begin
            x_busy = 0;
            kick_at = -10; check_at = -10; fin_at = -10; waiting = 0;
        end else if (!x_busy) begin
            if (start) begin
                x_busy = 1; x_idx = 0; x_et = 0; x_eg = 0;
                x_begin = 1; kick_at = e;
            end
        end else if (e == kick_at + 1) begin
            waiting = 1;
            w0 = e + 1;
        end else if (waiting) begin
            if (src_done) begin
                waiting = 0;
                check_at = e + 1;
            end else if (e - w0 == TMO - 1) begin
                waiting = 0;
                x_et = 1;
                x_busy = 0;
            end
        end else if (e == check_at) begin
            x_idx++;
            if (GEOM_ON && (gen_pix != EXPP || gen_lines != EXPL)) x_eg = 1;
            if (x_idx == FN) begin
                x_sdone = 1;
                fin_at = e + 1;
            end else begin
                kick_at = e + GAP;
            end
        end else if (e == fin_at) begin
            x_busy = 0;
        end else if (e == kick_at) begin
            x_begin = 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            total++;
            if ({src_begin, busy, seq_done, err_timeout, err_geom} !==
                    {x_begin, x_busy, x_sdone, x_et, x_eg} || frame_idx !== 16'(x_idx))
                $display("FAIL model cyc=%0d got beg/busy/sd/et/eg=%b%b%b%b%b idx=%0d expected %b%b%b%b%b idx=%0d",
                         cyc, src_begin, busy, seq_done, err_timeout, err_geom, frame_idx,
                         x_begin, x_busy, x_sdone, x_et, x_eg, x_idx);
            else
                passed++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else passed++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_begin();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (src_begin === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk("wait_begin_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (busy === 1'b0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk("wait_idle_timeout", 0, 1);
    endtask

    // Caller sits on the begin cycle; lines are separated by two idle cycles.
    task automatic gen_frame(input bit drop);
        gen_pix = 0;
        gen_lines = 0;
        for (int l = 0; l < NL; l++) begin
            for (int p = 0; p < PPL; p++) begin
                @(negedge clk);
                src_valid = !(drop && l == NL - 1 && p == PPL - 1);
                if (src_valid) gen_pix++;
                if (p == 0) gen_lines++;
            end
            @(negedge clk);
            src_valid = 1'b0;
            @(negedge clk);
        end
        src_done = 1'b1;
        done_cyc = cyc;
        @(negedge clk);
        src_done = 1'b0;
    endtask

    int b0, s0, kc;

    initial begin
        tick(3);
        cmp_en = 1'b1;
        chk("reset_outputs", {src_begin, busy, seq_done, err_timeout, err_geom, frame_idx}, 0);
        rst = 1'b0;
        tick(2);

        // Two-frame sequence, with a stray start during the gap.
        b0 = n_beg; s0 = n_sd;
        pulse_start();
        wait_begin();
        gen_frame(1'b0);
        tick(3);
        pulse_start();
        wait_begin();
        chk("gap_interval", cyc - done_cyc, 1 + GAP + 1);
        gen_frame(1'b0);
        wait_idle();
        chk("seq_begins", n_beg - b0, 2);
        chk("seq_done_once", n_sd - s0, 1);
        chk("seq_frame_idx", frame_idx, 2);
        chk("seq_no_errors", {err_timeout, err_geom}, 0);

        // Timeout with src_done held low.
        tick(2);
        s0 = n_sd;
        pulse_start();
        kc = cyc;
        wait_idle();
        chk("timeout_busy_fall", cyc - kc, TMO + 1);
        chk("timeout_flag", err_timeout, 1);
        chk("timeout_no_seq_done", n_sd - s0, 0);

        // Abort in the gap after frame 1.
        tick(2);
        pulse_start();
        wait_begin();
        gen_frame(1'b0);
        tick(4);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_frame_idx", frame_idx, 1);
        chk("abort_err_cleared_by_start", err_timeout, 0);
        b0 = n_beg;
        tick(40);
        chk("abort_no_begin", n_beg - b0, 0);

        // One dropped pixel in frame 1.
        s0 = n_sd;
        pulse_start();
        wait_begin();
        gen_frame(1'b1);
        wait_begin();
        gen_frame(1'b0);
        wait_idle();
        chk("geom_flag", err_geom, 32'(GEOM_ON));
        chk("geom_seq_done", n_sd - s0, 1);
        chk("geom_frame_idx", frame_idx, 2);

        // src_done on the last timeout cycle wins.
        tick(2);
        gen_pix = 0;
        gen_lines = 0;
        pulse_start();
        tick(TMO);
        src_done = 1'b1;
        tick(1);
        src_done = 1'b0;
        tick(1);
        chk("coincide_no_timeout", err_timeout, 0);
        chk("coincide_frame_idx", frame_idx, 1);
        chk("coincide_busy", busy, 1);
        wait_begin();
        gen_frame(1'b0);
        wait_idle();

        // Reset while waiting for done.
        tick(2);
        pulse_start();
        tick(5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_in_wait", {src_begin, busy, seq_done, err_timeout, err_geom, frame_idx}, 0);
        tick(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
